fp_mul_result_fifo: RTL

//  Downstream stage of the my_fp_mul wrapper. That wrapper has its result

---
 rtl/fp_mul_result_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/fp_mul_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_result_fifo
// Description : Result buffer behind the fp32 multiplier. Captures every valid
//               product {tuser, tdata} into a first-word-fall-through FIFO,
//               tracks sticky IEEE exception flags, and counts products that
//               are dropped because the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_result_fifo #(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             aclken,
    input  logic             in_tvalid,
    input  logic [31:0]      in_tdata,
    input  logic [2:0]       in_tuser,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [31:0]      out_tdata,
    output logic [2:0]       out_tuser,
    output logic [AW:0]      level,
    output logic             full,
    output logic [2:0]       sticky_flags,
    output logic             overrun,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             flags_clr
);

    localparam logic [AW:0]      c_LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    // Storage: {tuser, tdata}; deliberately not reset.
    logic [34:0]      mem_q [DEPTH];

    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic [2:0]       sticky_q, sticky_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_beat;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [34:0]      w_head;

    // Handshake decode: write side is gated by aclken, read side is not.
    assign w_beat = aclken & in_tvalid;
    assign w_pop  = out_tvalid & out_tready;
    assign w_push = w_beat & (~full | w_pop);
    assign w_drop = w_beat & full & ~w_pop;

    // Head of queue is shown directly; forced to zero while empty so the
    // outputs are clean after reset even though storage is not initialised.
    assign w_head       = mem_q[rd_q];
    assign out_tvalid   = (level_q != '0);
    assign out_tdata    = out_tvalid ? w_head[31:0]  : 32'd0;
    assign out_tuser    = out_tvalid ? w_head[34:32] : 3'd0;
    assign level        = level_q;
    assign full         = (level_q == c_LEVEL_FULL);
    assign sticky_flags = sticky_q;
    assign overrun      = ovr_q;
    assign drop_cnt     = cnt_q;

    // Next-state for pointers, occupancy and the flag/drop bookkeeping.
    // A clear in the same cycle as a beat is applied before that beat.
    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        level_d  = level_q;
        sticky_d = flags_clr ? 3'd0 : sticky_q;
        ovr_d    = flags_clr ? 1'b0 : ovr_q;
        cnt_d    = flags_clr ? '0   : cnt_q;

        if (w_push) wr_d = wr_q + 1'b1;
        if (w_pop)  rd_d = rd_q + 1'b1;

        if (w_push && !w_pop)      level_d = level_q + 1'b1;
        else if (w_pop && !w_push) level_d = level_q - 1'b1;

        if (w_beat) sticky_d = sticky_d | in_tuser;

        if (w_drop) begin
            ovr_d = 1'b1;
            if (cnt_d != c_CNT_MAX) cnt_d = cnt_d + 1'b1;
        end
    end

    // Storage write; only accepted beats land in the array.
    always_ff @(posedge aclk) begin
        if (w_push) mem_q[wr_q] <= {in_tuser, in_tdata};
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            sticky_q <= 3'd0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire
